// File: rtl/lcd_pkg.sv
// lcd_pkg: state encoding, default bus timing and HD44780 constants shared by the
// LCD reader and writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_SETUP,
    RD_E_HIGH,
    RD_HOLD,
    RD_RECOVER
  } lcd_rd_state_t;

  localparam int LCD_DATA_W    = 8;
  localparam int LCD_AC_W      = 7;
  localparam int LCD_BF_BIT    = 7;

  localparam int LCD_T_AS      = 2;
  localparam int LCD_T_PW      = 25;
  localparam int LCD_T_H       = 2;
  localparam int LCD_T_REC     = 25;
  localparam int LCD_MAX_POLLS = 1000;

  localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME         = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY_MODE   = 8'h04;
  localparam logic [7:0] LCD_CMD_DISPLAY_CTRL = 8'h08;
  localparam logic [7:0] LCD_CMD_SHIFT        = 8'h10;
  localparam logic [7:0] LCD_CMD_FUNCTION_SET = 8'h20;
  localparam logic [7:0] LCD_CMD_SET_CGRAM    = 8'h40;
  localparam logic [7:0] LCD_CMD_SET_DDRAM    = 8'h80;

  function automatic int lcd_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// lcd_reader_if: request/response handshake between a client and the LCD read engine.
import lcd_pkg::*;

interface lcd_reader_if;
  logic                  req;
  logic                  req_rs;
  logic                  req_poll;
  logic                  ready;
  logic                  rd_valid;
  logic [LCD_DATA_W-1:0] rd_data;
  logic                  busy_flag;
  logic [LCD_AC_W-1:0]   addr_cnt;
  logic                  timeout;

  modport master (
    output req, req_rs, req_poll,
    input  ready, rd_valid, rd_data, busy_flag, addr_cnt, timeout
  );

  modport slave (
    input  req, req_rs, req_poll,
    output ready, rd_valid, rd_data, busy_flag, addr_cnt, timeout
  );
endinterface

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: two-flop synchroniser for the asynchronous LCD data bus.
import lcd_pkg::*;

module lcd_bus_sync #(
  parameter int W = LCD_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read-cycle engine (RW=1) returning BF/AC or one DDRAM/CGRAM byte.
// Poll mode repeats BF/AC reads until BF clears or the poll budget is spent.
import lcd_pkg::*;

module lcd_reader #(
  parameter int T_AS      = LCD_T_AS,
  parameter int T_PW      = LCD_T_PW,
  parameter int T_H       = LCD_T_H,
  parameter int T_REC     = LCD_T_REC,
  parameter int MAX_POLLS = LCD_MAX_POLLS
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_reader_if.slave           bus,
  output logic                  o_lcd_rs,
  output logic                  o_lcd_rw,
  output logic                  o_lcd_e,
  output logic                  o_lcd_bus_oe,
  input  logic [LCD_DATA_W-1:0] i_lcd_data_in
);
  localparam int CNT_W  = $clog2(lcd_max4(T_AS, T_PW, T_H, T_REC)) + 1;
  localparam int POLL_W = $clog2(MAX_POLLS + 1);

  localparam logic [CNT_W-1:0]  CNT_AS    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0]  CNT_PW    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0]  CNT_H     = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0]  CNT_REC   = CNT_W'(T_REC - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS);

  lcd_rd_state_t         r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [POLL_W-1:0]     r_poll_cnt, w_poll_cnt_next;
  logic                  r_poll, w_poll_next;
  logic [LCD_DATA_W-1:0] r_sample, w_sample_next;
  logic                  r_ready, w_ready_next;
  logic                  r_rd_valid, w_rd_valid_next;
  logic [LCD_DATA_W-1:0] r_rd_data, w_rd_data_next;
  logic                  r_bf, w_bf_next;
  logic [LCD_AC_W-1:0]   r_ac, w_ac_next;
  logic                  r_timeout, w_timeout_next;
  logic                  r_rs, w_rs_next;
  logic                  r_rw, w_rw_next;
  logic                  r_e, w_e_next;
  logic                  r_oe, w_oe_next;
  logic [LCD_DATA_W-1:0] w_sync;
  logic                  w_cnt_zero;

  lcd_bus_sync #(.W(LCD_DATA_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_lcd_data_in),
    .o_q (w_sync)
  );

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RD_IDLE;
      r_cnt      <= '0;
      r_poll_cnt <= '0;
      r_poll     <= 1'b0;
      r_sample   <= '0;
      r_ready    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_bf       <= 1'b0;
      r_ac       <= '0;
      r_timeout  <= 1'b0;
      r_rs       <= 1'b0;
      r_rw       <= 1'b0;
      r_e        <= 1'b0;
      r_oe       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_poll_cnt <= w_poll_cnt_next;
      r_poll     <= w_poll_next;
      r_sample   <= w_sample_next;
      r_ready    <= w_ready_next;
      r_rd_valid <= w_rd_valid_next;
      r_rd_data  <= w_rd_data_next;
      r_bf       <= w_bf_next;
      r_ac       <= w_ac_next;
      r_timeout  <= w_timeout_next;
      r_rs       <= w_rs_next;
      r_rw       <= w_rw_next;
      r_e        <= w_e_next;
      r_oe       <= w_oe_next;
    end
  end

  // Every output is computed here one cycle ahead so the pins come straight from flops.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_poll_cnt_next = r_poll_cnt;
    w_poll_next     = r_poll;
    w_sample_next   = r_sample;
    w_ready_next    = r_ready;
    w_rd_valid_next = 1'b0;
    w_rd_data_next  = r_rd_data;
    w_bf_next       = r_bf;
    w_ac_next       = r_ac;
    w_timeout_next  = r_timeout;
    w_rs_next       = r_rs;
    w_rw_next       = r_rw;
    w_e_next        = r_e;
    w_oe_next       = r_oe;

    unique case (r_state)
      RD_IDLE: begin
        if (bus.req) begin
          w_state_next    = RD_SETUP;
          w_cnt_next      = CNT_AS;
          w_poll_cnt_next = '0;
          w_poll_next     = bus.req_poll & ~bus.req_rs;
          w_ready_next    = 1'b0;
          w_timeout_next  = 1'b0;
          w_rs_next       = bus.req_rs;
          w_rw_next       = 1'b1;
          w_oe_next       = 1'b0;
        end
      end
      RD_SETUP: begin
        if (w_cnt_zero) begin
          w_state_next = RD_E_HIGH;
          w_cnt_next   = CNT_PW;
          w_e_next     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RD_E_HIGH: begin
        if (w_cnt_zero) begin
          w_state_next  = RD_HOLD;
          w_cnt_next    = CNT_H;
          w_e_next      = 1'b0;
          w_sample_next = w_sync;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RD_HOLD: begin
        if (w_cnt_zero) begin
          w_state_next    = RD_RECOVER;
          w_cnt_next      = CNT_REC;
          w_rd_valid_next = 1'b1;
          w_rd_data_next  = r_sample;
          if (!r_rs) begin
            w_bf_next = r_sample[LCD_BF_BIT];
            w_ac_next = r_sample[LCD_AC_W-1:0];
            if (r_poll_cnt != POLL_LAST) w_poll_cnt_next = r_poll_cnt + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RD_RECOVER: begin
        if (!w_cnt_zero) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (r_poll && r_bf && (r_poll_cnt != POLL_LAST)) begin
          w_state_next = RD_SETUP;
          w_cnt_next   = CNT_AS;
        end else begin
          w_state_next   = RD_IDLE;
          w_timeout_next = r_poll && r_bf;
          w_ready_next   = 1'b1;
          w_rw_next      = 1'b0;
          w_oe_next      = 1'b1;
        end
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  assign bus.ready     = r_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.busy_flag = r_bf;
  assign bus.addr_cnt  = r_ac;
  assign bus.timeout   = r_timeout;
  assign o_lcd_rs      = r_rs;
  assign o_lcd_rw      = r_rw;
  assign o_lcd_e       = r_e;
  assign o_lcd_bus_oe  = r_oe;
endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: directed checks of the LCD read engine against a simple LCD bus model.
module tb_lcd_reader;
  logic       clk;
  logic       rst;
  logic       lcdRs, lcdRw, lcdE, lcdBusOe;
  logic [7:0] lcdDataIn;
  logic [7:0] modelVal;
  int         busyLeft;
  int         ePulses;
  int         validCount;
  int         testsRun;
  int         testsFailed;
  int         validAt, readyAt, eHigh, rsErr, readyHigh;

  lcd_reader_if rif ();

  lcd_reader #(.MAX_POLLS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (rif),
    .o_lcd_rs      (lcdRs),
    .o_lcd_rw      (lcdRw),
    .o_lcd_e       (lcdE),
    .o_lcd_bus_oe  (lcdBusOe),
    .i_lcd_data_in (lcdDataIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LCD model: returns BF=1 for busyLeft more reads, otherwise the plain model byte.
  assign lcdDataIn = lcdE ? ((busyLeft > 0) ? (8'h80 | modelVal) : modelVal) : 8'h5A;

  always @(negedge lcdE) if (busyLeft > 0) busyLeft = busyLeft - 1;
  always @(posedge lcdE) ePulses = ePulses + 1;
  always @(posedge clk) if (rif.rd_valid) validCount = validCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launches one request and follows it until ready returns or maxCycles expire.
  task automatic applyStimulus(input logic rs, input logic poll, input int maxCycles, input int pulseAt);
    validAt = -1; readyAt = -1; eHigh = 0; rsErr = 0;
    ePulses = 0; validCount = 0;
    @(negedge clk);
    rif.req = 1'b1; rif.req_rs = rs; rif.req_poll = poll;
    @(posedge clk); #1;
    rif.req = 1'b0;
    checkOutput("acceptReady", rif.ready, 0);
    checkOutput("acceptOe", lcdBusOe, 0);
    checkOutput("acceptRw", lcdRw, 1);
    checkOutput("acceptRs", lcdRs, rs);
    checkOutput("acceptTimeout", rif.timeout, 0);
    for (int n = 1; n <= maxCycles; n++) begin
      @(posedge clk); #1;
      rif.req = (n == pulseAt);
      if (lcdE) eHigh++;
      if (lcdRs !== rs) rsErr++;
      if (rif.rd_valid && validAt < 0) validAt = n;
      if (rif.ready) begin
        readyAt = n;
        break;
      end
    end
    rif.req = 1'b0;
  endtask

  initial begin
    testsRun = 0; testsFailed = 0;
    ePulses = 0; validCount = 0;
    busyLeft = 0; modelVal = 8'h00;
    rif.req = 1'b0; rif.req_rs = 1'b0; rif.req_poll = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReady", rif.ready, 1);
    checkOutput("rstE", lcdE, 0);
    checkOutput("rstRw", lcdRw, 0);
    checkOutput("rstRs", lcdRs, 0);
    checkOutput("rstOe", lcdBusOe, 1);
    checkOutput("rstValid", rif.rd_valid, 0);
    checkOutput("rstData", rif.rd_data, 0);
    checkOutput("rstBf", rif.busy_flag, 0);
    checkOutput("rstAc", rif.addr_cnt, 0);
    checkOutput("rstTimeout", rif.timeout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single BF/AC read
    modelVal = 8'h25; busyLeft = 0;
    applyStimulus(1'b0, 1'b0, 200, 0);
    checkOutput("bfValidAt", validAt, 29);
    checkOutput("bfReadyAt", readyAt, 54);
    checkOutput("bfEHigh", eHigh, 25);
    checkOutput("bfValidCnt", validCount, 1);
    checkOutput("bfData", rif.rd_data, 8'h25);
    checkOutput("bfBusy", rif.busy_flag, 0);
    checkOutput("bfAc", rif.addr_cnt, 7'h25);
    checkOutput("bfRsHeld", rsErr, 0);
    checkOutput("bfIdleOe", lcdBusOe, 1);
    checkOutput("bfIdleRw", lcdRw, 0);

    // Data read leaves BF/AC alone
    modelVal = 8'h4C;
    applyStimulus(1'b1, 1'b0, 200, 0);
    checkOutput("dataValidAt", validAt, 29);
    checkOutput("dataReadyAt", readyAt, 54);
    checkOutput("dataByte", rif.rd_data, 8'h4C);
    checkOutput("dataRsHeld", rsErr, 0);
    checkOutput("dataBusy", rif.busy_flag, 0);
    checkOutput("dataAc", rif.addr_cnt, 7'h25);

    // Poll: three busy reads then clear
    modelVal = 8'h11; busyLeft = 3;
    applyStimulus(1'b0, 1'b1, 400, 0);
    checkOutput("pollReadyAt", readyAt, 216);
    checkOutput("pollValidCnt", validCount, 4);
    checkOutput("pollEPulses", ePulses, 4);
    checkOutput("pollTimeout", rif.timeout, 0);
    checkOutput("pollBusy", rif.busy_flag, 0);
    checkOutput("pollAc", rif.addr_cnt, 7'h11);

    // Poll with BF stuck high runs out after MAX_POLLS reads
    modelVal = 8'h07; busyLeft = 100;
    applyStimulus(1'b0, 1'b1, 400, 0);
    checkOutput("toReadyAt", readyAt, 216);
    checkOutput("toEPulses", ePulses, 4);
    checkOutput("toValidCnt", validCount, 4);
    checkOutput("toTimeout", rif.timeout, 1);
    checkOutput("toBusy", rif.busy_flag, 1);
    checkOutput("toData", rif.rd_data, 8'h87);
    checkOutput("toReady", rif.ready, 1);

    // Request pulsed during E high is dropped; accept also clears timeout
    modelVal = 8'h33; busyLeft = 0;
    applyStimulus(1'b0, 1'b0, 200, 10);
    checkOutput("ignReadyAt", readyAt, 54);
    checkOutput("ignEPulses", ePulses, 1);
    checkOutput("ignValidCnt", validCount, 1);
    checkOutput("ignTimeout", rif.timeout, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ignStaysIdle", ePulses, 1);
    checkOutput("ignReadyHeld", rif.ready, 1);

    // Request held high in idle gives back-to-back cycles
    modelVal = 8'h12; busyLeft = 0;
    ePulses = 0; validCount = 0; readyHigh = 0;
    @(negedge clk);
    rif.req = 1'b1; rif.req_rs = 1'b0; rif.req_poll = 1'b0;
    @(posedge clk); #1;
    for (int n = 1; n <= 108; n++) begin
      @(posedge clk); #1;
      if (rif.ready) readyHigh++;
      if (n == 60) rif.req = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput("b2bReadyOnce", readyHigh, 1);
    checkOutput("b2bReady2", rif.ready, 1);
    checkOutput("b2bEPulses", ePulses, 2);
    checkOutput("b2bValidCnt", validCount, 2);

    // Reset in the middle of E high
    ePulses = 0; validCount = 0;
    @(negedge clk);
    rif.req = 1'b1;
    @(posedge clk); #1;
    rif.req = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    checkOutput("midEHigh", lcdE, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRstE", lcdE, 0);
    checkOutput("midRstReady", rif.ready, 1);
    checkOutput("midRstOe", lcdBusOe, 1);
    checkOutput("midRstRw", lcdRw, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("midNoValid", validCount, 0);
    checkOutput("midEPulses", ePulses, 1);
    checkOutput("midIdleReady", rif.ready, 1);
    checkOutput("midData", rif.rd_data, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
